// File: rtl/ddfs_phase_gen.sv
// ddfs_phase_gen
// ---------------
// Phase accumulator and sine-ROM address generator for the DDFS datapath.
// On each sample tick the PW-bit phase advances by (carrier + offset), a phase
// offset is added, and the top ADDR_WIDTH bits become the ROM read address.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset_n     asynchronous active-low reset, clears every register
//   tick        single-cycle sample-rate strobe
//   fccw        carrier frequency control word (unsigned)
//   focw        frequency offset word (two's complement)
//   pha         phase offset word
//   load        capture fccw/focw/pha into shadow registers
//   sync_clr    request a phase accumulator clear on the next tick
//   r_addr      ROM read address
//   addr_valid  one-cycle pulse: r_addr updated this cycle
//   data_valid  one-cycle pulse: ROM registered data matches latest r_addr
//   wrap        one-cycle pulse with addr_valid on forward accumulator overflow
//
// Strobe semantics: addr_valid, data_valid and wrap are pure valid pulses with
// no ready/backpressure. A tick in cycle T gives addr_valid in T+1 and
// data_valid in T+2; every tick yields exactly one pulse of each, so
// back-to-back ticks give continuous pulses.

module ddfs_phase_gen #(
  parameter int PW         = 30,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [PW-1:0]         fccw,
  input  logic [PW-1:0]         focw,
  input  logic [PW-1:0]         pha,
  input  logic                  load,
  input  logic                  sync_clr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  addr_valid,
  output logic                  data_valid,
  output logic                  wrap
);

  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         fccw_a_q, fccw_a_d, focw_a_q, focw_a_d, pha_a_q, pha_a_d;
  logic [PW-1:0]         fccw_s_q, fccw_s_d, focw_s_q, focw_s_d, pha_s_q, pha_s_d;
  logic                  upd_pend_q, upd_pend_d;
  logic                  clr_pend_q, clr_pend_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wrap_q, wrap_d;

  logic [PW-1:0] eff_fccw, eff_focw, eff_pha;
  logic          eff_clr;
  logic [PW+1:0] sum_w;
  logic          carry;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] phase_w;

  // A pending load takes effect on the very tick that commits it.
  assign eff_fccw = upd_pend_q ? fccw_s_q : fccw_a_q;
  assign eff_focw = upd_pend_q ? focw_s_q : focw_a_q;
  assign eff_pha  = upd_pend_q ? pha_s_q  : pha_a_q;
  assign eff_clr  = sync_clr | clr_pend_q;

  // Two guard bits hold the true signed sum. Top bits 01/10 mean the result
  // landed at or above 2**PW (forward overflow); 11 means it went negative
  // (backward wrap from a negative offset), which must not flag wrap.
  assign sum_w    = {2'b00, acc_q} + {2'b00, eff_fccw} + {{2{eff_focw[PW-1]}}, eff_focw};
  assign carry    = sum_w[PW+1] ^ sum_w[PW];
  assign acc_next = eff_clr ? '0 : sum_w[PW-1:0];
  assign phase_w  = acc_next + eff_pha;

  always_comb begin
    acc_d        = acc_q;
    r_addr_d     = r_addr_q;
    fccw_a_d     = fccw_a_q;
    focw_a_d     = focw_a_q;
    pha_a_d      = pha_a_q;
    fccw_s_d     = fccw_s_q;
    focw_s_d     = focw_s_q;
    pha_s_d      = pha_s_q;
    upd_pend_d   = upd_pend_q;
    clr_pend_d   = clr_pend_q;
    wrap_d       = 1'b0;
    addr_valid_d = tick;
    data_valid_d = addr_valid_q;

    if (tick) begin
      acc_d      = acc_next;
      r_addr_d   = ADDR_WIDTH'(phase_w >> (PW - ADDR_WIDTH));
      wrap_d     = carry & ~eff_clr;
      clr_pend_d = 1'b0;
      if (upd_pend_q) begin
        fccw_a_d   = fccw_s_q;
        focw_a_d   = focw_s_q;
        pha_a_d    = pha_s_q;
        upd_pend_d = 1'b0;
      end
    end else if (sync_clr) begin
      clr_pend_d = 1'b1;
    end

    // A load coincident with a tick lands in shadow and waits for the next tick.
    if (load) begin
      fccw_s_d   = fccw;
      focw_s_d   = focw;
      pha_s_d    = pha;
      upd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      fccw_a_q     <= '0;
      focw_a_q     <= '0;
      pha_a_q      <= '0;
      fccw_s_q     <= '0;
      focw_s_q     <= '0;
      pha_s_q      <= '0;
      upd_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      r_addr_q     <= '0;
      addr_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fccw_a_q     <= fccw_a_d;
      focw_a_q     <= focw_a_d;
      pha_a_q      <= pha_a_d;
      fccw_s_q     <= fccw_s_d;
      focw_s_q     <= focw_s_d;
      pha_s_q      <= pha_s_d;
      upd_pend_q   <= upd_pend_d;
      clr_pend_q   <= clr_pend_d;
      r_addr_q     <= r_addr_d;
      addr_valid_q <= addr_valid_d;
      data_valid_q <= data_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign r_addr     = r_addr_q;
  assign addr_valid = addr_valid_q;
  assign data_valid = data_valid_q;
  assign wrap       = wrap_q;

endmodule
